game_control: RTL and testbench
===============================

GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 Parameter LIVES, default 3: lives granted at game start; legal range 1..3.
REQ-002 Parameter DEATH_CYCLES, default 65_000_000: clk cycles spent in ST_DEATH; at least 2.
REQ-003 Parameter WIN_CYCLES, default 130_000_000: clk cycles spent in ST_WIN; at least 2.
REQ-004 Parameter WIN_YPOS, default 96: character ypos at or above the goal platform (ypos <= WIN_YPOS).
REQ-005 clk  in  1  system clock; the only clock of the block.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 key_start  in  1  start key, level, synchronous to clk.
REQ-008 hit  in  1  character/barrel collision, level, synchronous to clk.
REQ-009 ypos  in  12  current character ypos from the movement block.
REQ-010 start_game  out  1  enables character movement; high only in ST_PLAY.
REQ-011 respawn  out  1  one-cycle pulse that returns character and barrels to spawn positions.
REQ-012 lives  out  2  remaining lives.
REQ-013 screen_sel  out  3  screen to display: 0 menu, 1 play, 2 death, 3 win, 4 game over.

Function
REQ-014 The block SHALL implement the states ST_MENU, ST_PLAY, ST_DEATH, ST_WIN and ST_OVER, each held in a registered state variable.
REQ-015 The block SHALL register key_start each cycle and derive start_edge = key_start & ~key_start_q; only start_edge triggers state changes.
REQ-016 From ST_MENU on start_edge, the block SHALL go to ST_PLAY, load lives = LIVES, and pulse respawn in the first ST_PLAY cycle.
REQ-017 In ST_PLAY, if hit = 1 the block SHALL go to ST_DEATH and decrement lives by 1; hit takes priority over the win condition when both are true in the same cycle.
REQ-018 In ST_PLAY, if hit = 0 and ypos <= WIN_YPOS, the block SHALL go to ST_WIN.
REQ-019 In ST_DEATH, a cycle counter SHALL count from 0 and the state SHALL be left when the count equals DEATH_CYCLES-1.
REQ-019a On leaving ST_DEATH with lives != 0, the block SHALL go to ST_PLAY with a respawn pulse; with lives == 0 it SHALL go to ST_OVER.
REQ-020 In ST_WIN, the same counter SHALL count to WIN_CYCLES-1, after which the block SHALL return to ST_MENU.
REQ-021 From ST_OVER on start_edge, the block SHALL return to ST_MENU; no other input has any effect in ST_OVER.
REQ-022 The cycle counter SHALL be cleared on every state change and SHALL be sized for max(DEATH_CYCLES, WIN_CYCLES); it SHALL never wrap.
REQ-023 Lives SHALL never underflow: a decrement at lives == 0 is impossible by construction, and the block SHALL hold lives at 0 in that case.
REQ-024 hit SHALL be ignored in every state other than ST_PLAY.
REQ-025 start_edge SHALL be ignored in ST_PLAY, ST_DEATH and ST_WIN.
REQ-026 All outputs SHALL be registered; respawn is high for exactly one cycle per entry into ST_PLAY.
REQ-027 screen_sel SHALL be updated in the same cycle as the state register.
REQ-028 An undefined state encoding SHALL recover to ST_MENU on the next clock.

Reset
REQ-029 While rst = 0 the block SHALL hold: state ST_MENU, start_game 0, respawn 0, lives 0, screen_sel 0, counter 0, key_start_q 0.
REQ-030 Reset assertion SHALL take effect asynchronously, including in the middle of ST_DEATH or ST_WIN, and SHALL abort any count in progress.
REQ-031 Reset release SHALL be synchronised to clk with a 2-flop synchroniser; the first active cycle follows the second rising edge after release.
REQ-032 key_start held high through reset release SHALL NOT start the game; a new rising edge is required.

Verification (DEATH_CYCLES=4, WIN_CYCLES=6, LIVES=3, WIN_YPOS=96)
REQ-033 Start: key_start 0->1 in ST_MENU -> next cycle start_game=1, screen_sel=1, lives=3, respawn high 1 cycle.
REQ-034 Death: hit=1 for 1 cycle in play -> lives=2, screen_sel=2, start_game=0 for 4 cycles, then ST_PLAY with respawn pulse.
REQ-035 Game over: three hits -> lives=0, screen_sel=4 after the 4-cycle ST_DEATH; key_start edge -> screen_sel=0.
REQ-036 Win and priority: ypos=96 with hit=1 in the same cycle -> ST_DEATH; ypos=96 with hit=0 -> screen_sel=3 for 6 cycles, then 0.
REQ-037 Reset mid-death: rst=0 on counter=2 in ST_DEATH -> all outputs at reset values immediately; key_start held high through release -> stays ST_MENU.
REQ-038 Held key: key_start held high for 100 cycles in ST_MENU -> exactly one transition and one respawn pulse.

Source files
------------

// File: rtl/game_control.sv
// Game flow controller: menu -> play -> death/win -> over, with a lives count,
// timed death/win screens and a respawn pulse on every entry into play.
module game_control #(
  parameter int LIVES        = 3,
  parameter int DEATH_CYCLES = 65_000_000,
  parameter int WIN_CYCLES   = 130_000_000,
  parameter int WIN_YPOS     = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_start,
  input  logic        hit,
  input  logic [11:0] ypos,
  output logic        start_game,
  output logic        respawn,
  output logic [1:0]  lives,
  output logic [2:0]  screen_sel
);

  // State encoding; the values match the screen numbers shown for each state.
  localparam logic [2:0] ST_MENU  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_DEATH = 3'd2;
  localparam logic [2:0] ST_WIN   = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  // The counter only has to reach the larger of the two timed-state lengths.
  localparam int MAX_CYC = (DEATH_CYCLES > WIN_CYCLES) ? DEATH_CYCLES : WIN_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [11:0]      GOAL_YPOS  = 12'(WIN_YPOS);

  // Screen selection for a given state; unknown encodings show the menu.
  function automatic logic [2:0] screen_of(input logic [2:0] st);
    logic [2:0] scr;
    case (st)
      ST_MENU:  scr = 3'd0;
      ST_PLAY:  scr = 3'd1;
      ST_DEATH: scr = 3'd2;
      ST_WIN:   scr = 3'd3;
      ST_OVER:  scr = 3'd4;
      default:  scr = 3'd0;
    endcase
    return scr;
  endfunction

  logic [1:0]       r_rst_sync;
  logic             r_key_q;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lives;
  logic             r_respawn;
  logic             r_start_game;
  logic [2:0]       r_screen_sel;

  logic             w_active;
  logic             w_start_edge;
  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_lives_nxt;
  logic             w_respawn_nxt;

  assign w_active     = r_rst_sync[1];
  assign w_start_edge = key_start & ~r_key_q;

  assign start_game = r_start_game;
  assign respawn    = r_respawn;
  assign lives      = r_lives;
  assign screen_sel = r_screen_sel;

  // Reset synchroniser: assert immediately, release after two clock edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  // Next-state, counter, lives and respawn decisions for the game flow.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_lives_nxt   = r_lives;
    w_respawn_nxt = 1'b0;
    case (r_state)
      ST_MENU: begin
        if (w_start_edge) begin
          w_state_nxt   = ST_PLAY;
          w_lives_nxt   = LIVES_INIT;
          w_respawn_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_MENU;
        end
      end
      ST_PLAY: begin
        // A collision wins over reaching the goal in the same cycle.
        if (hit) begin
          w_state_nxt = ST_DEATH;
          w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : (r_lives - 2'd1);
        end else if (ypos <= GOAL_YPOS) begin
          w_state_nxt = ST_WIN;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_DEATH: begin
        if (r_cnt == DEATH_LAST) begin
          if (r_lives != 2'd0) begin
            w_state_nxt   = ST_PLAY;
            w_respawn_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_OVER;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_WIN: begin
        if (r_cnt == WIN_LAST) begin
          w_state_nxt = ST_MENU;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_OVER: begin
        if (w_start_edge) begin
          w_state_nxt = ST_MENU;
        end else begin
          w_state_nxt = ST_OVER;
        end
      end
      default: begin
        w_state_nxt = ST_MENU;
        w_lives_nxt = 2'd0;
      end
    endcase
    // Every state change restarts the timer for the state being entered.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = CNT_ZERO;
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  // State and output registers; held at reset values until the synchroniser releases.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_q      <= 1'b0;
      r_state      <= ST_MENU;
      r_cnt        <= CNT_ZERO;
      r_lives      <= 2'd0;
      r_respawn    <= 1'b0;
      r_start_game <= 1'b0;
      r_screen_sel <= 3'd0;
    end else if (!w_active) begin
      // Track the key during release so a key already held does not count as a press.
      r_key_q      <= key_start;
      r_state      <= ST_MENU;
      r_cnt        <= CNT_ZERO;
      r_lives      <= 2'd0;
      r_respawn    <= 1'b0;
      r_start_game <= 1'b0;
      r_screen_sel <= 3'd0;
    end else begin
      r_key_q      <= key_start;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_lives      <= w_lives_nxt;
      r_respawn    <= w_respawn_nxt;
      r_start_game <= (w_state_nxt == ST_PLAY);
      r_screen_sel <= screen_of(w_state_nxt);
    end
  end

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural game model.
module tb_game_control;

  localparam int P_LIVES = 3;
  localparam int P_DEATH = 4;
  localparam int P_WIN   = 6;
  localparam int P_WY    = 96;

  // Model modes, numbered as the screens they show.
  localparam int M_MENU  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_DEATH = 2;
  localparam int M_WIN   = 3;
  localparam int M_OVER  = 4;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic        hit;
  logic [11:0] ypos;
  logic        start_game;
  logic        respawn;
  logic [1:0]  lives;
  logic [2:0]  screen_sel;

  int n_checks;
  int n_fails;

  // Behavioural model state.
  int m_mode;
  int m_lives;
  int m_left;
  int m_sync;
  bit m_prevkey;
  bit m_respawn;

  game_control #(
    .LIVES        (P_LIVES),
    .DEATH_CYCLES (P_DEATH),
    .WIN_CYCLES   (P_WIN),
    .WIN_YPOS     (P_WY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .hit        (hit),
    .ypos       (ypos),
    .start_game (start_game),
    .respawn    (respawn),
    .lives      (lives),
    .screen_sel (screen_sel)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    m_mode    = M_MENU;
    m_lives   = 0;
    m_left    = 0;
    m_sync    = 0;
    m_prevkey = 1'b0;
    m_respawn = 1'b0;
  endfunction

  // One rising edge of the game as the rules describe it.
  function automatic void model_step();
    bit press;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_sync < 2) begin
      m_sync    = m_sync + 1;
      m_prevkey = key_start;
      m_mode    = M_MENU;
      m_lives   = 0;
      m_respawn = 1'b0;
      return;
    end
    press     = key_start && !m_prevkey;
    m_prevkey = key_start;
    m_respawn = 1'b0;
    if (m_mode == M_MENU) begin
      if (press) begin
        m_mode    = M_PLAY;
        m_lives   = P_LIVES;
        m_respawn = 1'b1;
      end
    end else if (m_mode == M_PLAY) begin
      if (hit) begin
        m_mode  = M_DEATH;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_left  = P_DEATH;
      end else if (int'(ypos) <= P_WY) begin
        m_mode = M_WIN;
        m_left = P_WIN;
      end
    end else if (m_mode == M_DEATH) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_lives > 0) begin
          m_mode    = M_PLAY;
          m_respawn = 1'b1;
        end else begin
          m_mode = M_OVER;
        end
      end
    end else if (m_mode == M_WIN) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = M_MENU;
    end else begin
      if (press) m_mode = M_MENU;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".screen_sel"}, 32'(screen_sel), 32'(m_mode));
    chk({tag, ".start_game"}, 32'(start_game), 32'(m_mode == M_PLAY));
    chk({tag, ".respawn"},    32'(respawn),    32'(m_respawn));
    chk({tag, ".lives"},      32'(lives),      32'(m_lives));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Assert reset between edges and check that outputs drop at once.
  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
  endtask

  initial begin
    int pulses;
    int changes;
    logic [2:0] last_scr;
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b0;
    key_start = 1'b0;
    hit       = 1'b0;
    ypos      = 12'd500;
    #1;
    model_reset();
    check_all("reset");
    run("reset_hold", 3);
    rst = 1'b1;
    run("release", 3);

    // Start: a rising key edge enters play with full lives and one respawn.
    key_start = 1'b1;
    cycle("start");
    chk("start.lives3", 32'(lives), 32'd3);
    chk("start.respawn1", 32'(respawn), 32'd1);
    run("play", 3);
    key_start = 1'b0;

    // Hit together with the goal: the hit wins.
    ypos = 12'd96;
    hit  = 1'b1;
    cycle("prio");
    chk("prio.screen_death", 32'(screen_sel), 32'd2);
    hit  = 1'b0;
    ypos = 12'd500;
    run("death", 4);
    chk("death.back_to_play", 32'(screen_sel), 32'd1);
    chk("death.lives2", 32'(lives), 32'd2);

    // Reaching the goal: six win cycles then the menu.
    ypos = 12'd96;
    run("win", 6);
    ypos = 12'd500;
    run("win_exit", 2);
    chk("win.menu", 32'(screen_sel), 32'd0);

    // Game over after three hits, then a key edge returns to the menu.
    key_start = 1'b1;
    cycle("restart");
    key_start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      hit = 1'b1;
      cycle("hit");
      hit = 1'b0;
      run("dying", 5);
    end
    chk("over.screen4", 32'(screen_sel), 32'd4);
    chk("over.lives0", 32'(lives), 32'd0);
    hit = 1'b1;
    run("over_hit", 2);
    hit = 1'b0;
    key_start = 1'b1;
    run("over_key", 2);
    chk("over.menu", 32'(screen_sel), 32'd0);
    key_start = 1'b0;
    cycle("menu");

    // Reset in the middle of the death count with the key held through release.
    key_start = 1'b1;
    cycle("start2");
    hit = 1'b1;
    cycle("hit2");
    hit = 1'b0;
    run("death_cnt", 2);
    async_reset("mid_death_reset");
    run("rst_low", 2);
    rst = 1'b1;
    run("held_release", 6);
    chk("held_release.menu", 32'(screen_sel), 32'd0);

    // Key held for 100 cycles in the menu: exactly one transition and pulse.
    key_start = 1'b0;
    cycle("key_low");
    key_start = 1'b1;
    pulses   = 0;
    changes  = 0;
    last_scr = screen_sel;
    for (int i = 0; i < 100; i++) begin
      cycle("held");
      if (respawn === 1'b1) pulses++;
      if (screen_sel !== last_scr) changes++;
      last_scr = screen_sel;
    end
    chk("held.pulses", 32'(pulses), 32'd1);
    chk("held.transitions", 32'(changes), 32'd1);
    key_start = 1'b0;

    // Random play against the model, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) key_start = ~key_start;
      hit  = ($urandom_range(0, 11) == 0);
      ypos = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(80, 100))
                                         : 12'($urandom_range(97, 4095));
      if ($urandom_range(0, 399) == 0) begin
        async_reset("rnd_reset");
        run("rnd_rst_low", 2);
        rst = 1'b1;
      end
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
